imm_table_ctrl: RTL
===================

// Module: imm_table_ctrl
// PURPOSE
//  Writable 32-entry immediate table with its controller; replaces the fixed immediate lookup in decode.
//  - After reset, an init sequencer loads the default immediate set.
//  - The table then serves decode reads (1-cycle latency) and a config write port (valid/ready).
//  - A restore request reloads the defaults.
// PARAMETERS
//  AW     5   index width; table depth = 2**AW = 32
//  DW     8   immediate width
//  NDEF   25  number of non-zero-default entries (indices 0..NDEF-1)
// PORTS
//  Clk          in   1   clock; all state updates on posedge Clk
//  Reset        in   1   synchronous, active-high reset
//  rd_en        in   1   decode read request
//  rd_index     in   AW  decode read index
//  rd_value     out  DW  registered read data
//  rd_valid     out  1   rd_value holds data for the read sampled last cycle
//  cfg_valid    in   1   config write request
//  cfg_ready    out  1   config write accepted when cfg_valid & cfg_ready
//  cfg_index    in   AW  config write index
//  cfg_data     in   DW  config write data
//  restore_req  in   1   single-cycle pulse; reload defaults
//  busy         out  1   init sequence in progress
//  init_done    out  1   table valid; high in RUN
// BEHAVIOUR
//  Reset (sampled high at posedge):
//  - State=INIT, cnt=0, rd_value=0, rd_valid=0, init_done=0, busy=1, cfg_ready=0.
//  - Table contents are not cleared by Reset itself; INIT overwrites every entry.
//  FSM INIT:
//  - Each cycle with Reset low, writes entry[cnt] = DEF(cnt), then cnt++.
//  - When cnt==31 is written, next state is RUN. INIT lasts exactly 32 cycles.
//  - busy=1, init_done=0, cfg_ready=0.
//  - rd_en is ignored; rd_valid=0 and rd_value is held at its previous value.
//  DEF(i) for i=0..24:
//  - 0,1,2,3,4,5,6,14,16,30,31,32,33,60,91,109,142,170,204,224,225,240,247,254,85.
//  - DEF(25..31)=0.
//  FSM RUN:
//  - busy=0, init_done=1.
//  - cfg_ready = ~restore_req (combinational).
//  Read (RUN):
//  - rd_en=1 at edge N gives rd_value=entry[rd_index] and rd_valid=1 after edge N.
//  - rd_en=0 gives rd_valid=0 next cycle; rd_value holds.
//  Write (RUN):
//  - cfg_valid & cfg_ready writes entry[cfg_index]=cfg_data at the edge.
//  Same-cycle read and write, same index:
//  - The read returns the OLD value (read-before-write).
//  - A read of that index on the following cycle returns the new value.
//  Restore:
//  - restore_req in RUN goes to INIT next cycle with cnt=0.
//  - A cfg write presented in that cycle is not accepted (cfg_ready=0); the requester must retry after init_done.
//  - A read sampled that cycle completes normally (rd_valid=1 next cycle).
//  - restore_req during INIT is ignored; the sequence does not restart.
//  Reset mid-INIT or mid-RUN:
//  - Restarts INIT from cnt=0 on the first edge with Reset low.
//  - Any in-flight cfg write is dropped.
//  Widths and priority:
//  - All indices are in range (2**AW entries); no out-of-range handling.
//  - DW-bit data is stored unmodified.
//  - Priority: Reset > restore_req > cfg write.
// TESTING
//  1. Init sequence: Reset 2 cycles then low.
//     -> busy=1 for 32 cycles, then init_done=1.
//     -> Read idx 7 gives 14, idx 16 gives 142, idx 24 gives 85, idx 31 gives 0.
//  2. Read during init: rd_en=1, idx 3 at cycle 5 after Reset.
//     -> rd_valid stays 0 throughout INIT.
//  3. Config write in RUN: cfg_valid, idx 9, data 8'hA5.
//     -> cfg_ready=1 and write accepted; next read of idx 9 gives 8'hA5.
//  4. Same-cycle read and write, idx 14: write 8'h3C while rd_en=1.
//     -> rd_value=91; following read gives 8'h3C.
//  5. Restore with cfg_valid in the same cycle.
//     -> cfg_ready=0; busy=1 for 32 cycles; idx 9 reads 30 again after init_done.
//  6. Reset asserted at INIT cnt=10.
//     -> cnt restarts at 0; init_done asserts 32 cycles after Reset falls.

Source files
------------

// File: rtl/imm_table_ctrl.sv
// Writable immediate table for decode: an init sequencer loads the default set after reset
// or on restore, then the table serves registered reads and valid/ready config writes.
module imm_table_ctrl #(
  parameter int AW   = 5,
  parameter int DW   = 8,
  parameter int NDEF = 25
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_index,
  output logic [DW-1:0] rd_value,
  output logic          rd_valid,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [AW-1:0] cfg_index,
  input  logic [DW-1:0] cfg_data,
  input  logic          restore_req,
  output logic          busy,
  output logic          init_done
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic [DW-1:0] mem [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  function automatic logic [DW-1:0] def_imm(input logic [AW-1:0] i);
    int idx;
    int v;
    idx = int'(i);
    case (idx)
      0: v = 0;     1: v = 1;     2: v = 2;     3: v = 3;     4: v = 4;
      5: v = 5;     6: v = 6;     7: v = 14;    8: v = 16;    9: v = 30;
      10: v = 31;   11: v = 32;   12: v = 33;   13: v = 60;   14: v = 91;
      15: v = 109;  16: v = 142;  17: v = 170;  18: v = 204;  19: v = 224;
      20: v = 225;  21: v = 240;  22: v = 247;  23: v = 254;  24: v = 85;
      default: v = 0;
    endcase
    if (idx >= NDEF) v = 0;
    return DW'(v);
  endfunction

  assign busy      = (state == INIT);
  assign init_done = (state == RUN);
  assign cfg_ready = (state == RUN) && !restore_req;

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: if (cnt == LAST) state_nxt = RUN;
      RUN:  if (restore_req) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
      else               cnt <= '0;
    end
  end

  // Single table write port: init sequencer has the port in INIT, config writes in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cnt;
    wr_data = def_imm(cnt);
    if (!Reset) begin
      if (state == INIT) begin
        wr_en = 1'b1;
      end else if (cfg_valid && cfg_ready) begin
        wr_en   = 1'b1;
        wr_addr = cfg_index;
        wr_data = cfg_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read stage: samples the table before this edge's write lands (read-before-write).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_valid <= 1'b0;
      rd_value <= '0;
    end else if (state == RUN) begin
      rd_valid <= rd_en;
      if (rd_en) rd_value <= mem[rd_index];
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule
